// File: rtl/pcie_consts.sv
// Shared PCIe/packet-path constants and record types.
// Consumed by the descriptor request merger and its neighbours.
package pcie_consts;

  localparam int HEAD_UPD_FIFO_DEPTH = 16;
  localparam int DEF_NB_QUEUES       = 8192;
  localparam int DEF_QUEUE_ID_WIDTH  = $clog2(DEF_NB_QUEUES);

  typedef struct packed {
    logic [31:0] pkt_queue_id;
    logic [31:0] dsc_queue_id;
    logic [15:0] size;
    logic        needs_dsc;
    logic        descriptor_only;
  } pkt_meta_with_queues_t;

  typedef struct packed {
    logic [DEF_QUEUE_ID_WIDTH-1:0] queue_id;
  } head_upd_t;

  typedef enum logic {
    SRC_PKT = 1'b0,
    SRC_DSC = 1'b1
  } rr_src_e;

  function automatic pkt_meta_with_queues_t mk_dsc_only(
    input logic [31:0] qid
  );
    pkt_meta_with_queues_t r;
    r                 = '0;
    r.descriptor_only = 1'b1;
    r.pkt_queue_id    = qid;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wrapper_infill_mlab.sv
// Small show-ahead FIFO: rd_data_o is the head whenever !empty_o.
// Writes while full are ignored, even with a same-cycle read.
module fifo_wrapper_infill_mlab #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_en_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_wr;
  logic             do_rd;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_rd) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/pkt_dsc_request_merger.sv
// Merges RX packet metadata with head-pointer updates into one stream.
// Optional head-update coalescing: PKT_DSC_HEAD_COALESCE_EN.
module pkt_dsc_request_merger
  import pcie_consts::*;
#(
  parameter  int NB_QUEUES       = DEF_NB_QUEUES,
  parameter  int HEAD_FIFO_DEPTH = HEAD_UPD_FIFO_DEPTH,
  localparam int QW              = $clog2(NB_QUEUES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pkt_meta_with_queues_t in_pkt_meta_data,
  input  logic                  in_pkt_meta_valid,
  output logic                  in_pkt_meta_ready,
  input  logic [QW-1:0]         in_head_upd_queue_id,
  input  logic                  in_head_upd_valid,
  output logic                  in_head_upd_ready,
  output pkt_meta_with_queues_t out_meta_data,
  output logic                  out_meta_valid,
  input  logic                  out_meta_ready,
  output logic [31:0]           merged_cnt,
  output logic [31:0]           dsc_only_cnt,
  output logic [31:0]           coalesced_cnt
);

  pkt_meta_with_queues_t out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  rr_src_e               rr_q, rr_d;
  logic [31:0]           merged_q, merged_d;
  logic [31:0]           dsc_q, dsc_d;

  logic          fifo_full, fifo_empty;
  logic          fifo_push, fifo_pop;
  logic [QW-1:0] fifo_head;
  logic          fifo_ne, slot_free, fuse, both;
  logic          pick_pkt, pick_dsc, hu_acc;

  fifo_wrapper_infill_mlab #(
    .WIDTH (QW),
    .DEPTH (HEAD_FIFO_DEPTH)
  ) u_head_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (in_head_upd_queue_id),
    .wr_en_i   (fifo_push),
    .full_o    (fifo_full),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty)
  );

  assign fifo_ne   = !fifo_empty;
  assign slot_free = !out_valid_q || out_meta_ready;
  assign both      = fifo_ne && in_pkt_meta_valid;
  assign fuse      = both &&
    (in_pkt_meta_data.pkt_queue_id[QW-1:0] == fifo_head);
  assign pick_pkt  = fuse || (in_pkt_meta_valid &&
                     (!fifo_ne || rr_q == SRC_PKT));
  assign pick_dsc  = !fuse && fifo_ne &&
                     (!in_pkt_meta_valid || rr_q == SRC_DSC);

  assign in_pkt_meta_ready = rst && slot_free && pick_pkt;
  assign in_head_upd_ready = rst && !fifo_full;
  assign fifo_pop          = slot_free && (fuse || pick_dsc);
  assign hu_acc            = in_head_upd_valid && in_head_upd_ready;

  assign out_meta_data  = out_q;
  assign out_meta_valid = out_valid_q;
  assign merged_cnt     = merged_q;
  assign dsc_only_cnt   = dsc_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    rr_d        = rr_q;
    merged_d    = merged_q;
    dsc_d       = dsc_q;
    if (slot_free) begin
      out_valid_d = pick_pkt || pick_dsc;
      if (pick_pkt) begin
        out_d           = in_pkt_meta_data;
        out_d.needs_dsc = fuse;
        if (fuse) out_d.descriptor_only = 1'b0;
      end else if (pick_dsc) begin
        out_d = mk_dsc_only(32'(fifo_head));
      end
      if (fuse)     merged_d = merged_q + 32'd1;
      if (pick_dsc) dsc_d    = dsc_q + 32'd1;
      // Fused records do not consume a round-robin turn.
      if (both && !fuse)
        rr_d = (rr_q == SRC_PKT) ? SRC_DSC : SRC_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rr_q        <= SRC_PKT;
      merged_q    <= '0;
      dsc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      rr_q        <= rr_d;
      merged_q    <= merged_d;
      dsc_q       <= dsc_d;
    end
  end

`ifdef PKT_DSC_HEAD_COALESCE_EN
  logic [NB_QUEUES-1:0] pend_q, pend_d;
  logic [31:0]          coal_q, coal_d;
  logic                 drop;

  // A queue already waiting in the FIFO needs no second entry,
  // unless that entry leaves this very cycle.
  assign drop = pend_q[in_head_upd_queue_id] &&
    !(fifo_pop && fifo_head == in_head_upd_queue_id);
  assign fifo_push     = hu_acc && !drop;
  assign coalesced_cnt = coal_q;

  always_comb begin
    pend_d = pend_q;
    coal_d = coal_q;
    if (fifo_pop)  pend_d[fifo_head]            = 1'b0;
    if (fifo_push) pend_d[in_head_upd_queue_id] = 1'b1;
    if (hu_acc && drop) coal_d = coal_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      coal_q <= '0;
    end else begin
      pend_q <= pend_d;
      coal_q <= coal_d;
    end
  end
`else
  assign fifo_push     = hu_acc;
  assign coalesced_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_dsc_request_merger.sv
// Scoreboard bench for pkt_dsc_request_merger: directed scenarios
// plus randomized traffic checked against a queue-based model.
module tb_pkt_dsc_request_merger;
  import pcie_consts::*;

  localparam int QW    = 13;
  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  pkt_meta_with_queues_t in_pkt_meta_data;
  logic                  in_pkt_meta_valid;
  logic                  in_pkt_meta_ready;
  logic [QW-1:0]         in_head_upd_queue_id;
  logic                  in_head_upd_valid;
  logic                  in_head_upd_ready;
  pkt_meta_with_queues_t out_meta_data;
  logic                  out_meta_valid;
  logic                  out_meta_ready;
  logic [31:0]           merged_cnt;
  logic [31:0]           dsc_only_cnt;
  logic [31:0]           coalesced_cnt;

  pkt_dsc_request_merger dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_pkt_meta_data     (in_pkt_meta_data),
    .in_pkt_meta_valid    (in_pkt_meta_valid),
    .in_pkt_meta_ready    (in_pkt_meta_ready),
    .in_head_upd_queue_id (in_head_upd_queue_id),
    .in_head_upd_valid    (in_head_upd_valid),
    .in_head_upd_ready    (in_head_upd_ready),
    .out_meta_data        (out_meta_data),
    .out_meta_valid       (out_meta_valid),
    .out_meta_ready       (out_meta_ready),
    .merged_cnt           (merged_cnt),
    .dsc_only_cnt         (dsc_only_cnt),
    .coalesced_cnt        (coalesced_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Reference state: expected output records, waiting head updates,
  // queues with an update waiting, whose turn it is, record counts.
  pkt_meta_with_queues_t sb[$];
  int unsigned           hq[$];
  bit                    pend[8192];
  bit                    turn_dsc;
  int unsigned           m_merged, m_dsc, m_coal;

  pkt_meta_with_queues_t plist[$];
  int unsigned           hlist[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  function automatic pkt_meta_with_queues_t mk_pkt(input int unsigned q);
    pkt_meta_with_queues_t r;
    r.pkt_queue_id    = ($urandom & 32'hFFFF_E000) | (q & 32'h1FFF);
    r.dsc_queue_id    = $urandom;
    r.size            = 16'($urandom);
    r.needs_dsc       = 1'($urandom);
    r.descriptor_only = 1'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    hq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    turn_dsc = 1'b0;
    m_merged = 0;
    m_dsc    = 0;
    m_coal   = 0;
  endtask

  // Evaluated once per cycle with the inputs that the next edge sees.
  task automatic model_step(output bit acc_p, output bit acc_h);
    bit                    slot_free, full, has_upd, fuse;
    bit                    take_pkt, take_upd, drop;
    int unsigned           upd, popq;
    pkt_meta_with_queues_t r;
    acc_p = 1'b0;
    acc_h = 1'b0;
    if (!rst) begin
      chk("pkt_ready_in_reset", 128'(in_pkt_meta_ready), 128'(0));
      chk("hu_ready_in_reset", 128'(in_head_upd_ready), 128'(0));
      model_reset();
      return;
    end
    chk("merged_cnt", 128'(merged_cnt), 128'(m_merged));
    chk("dsc_only_cnt", 128'(dsc_only_cnt), 128'(m_dsc));
    chk("coalesced_cnt", 128'(coalesced_cnt), 128'(m_coal));
    slot_free = (sb.size() == 0);
    full      = (hq.size() == DEPTH);
    has_upd   = (hq.size() > 0);
    upd       = has_upd ? hq[0] : 0;
    fuse      = has_upd && in_pkt_meta_valid &&
                ((in_pkt_meta_data.pkt_queue_id & 32'h1FFF) == upd);
    take_pkt  = 1'b0;
    take_upd  = 1'b0;
    if (slot_free) begin
      if (fuse) begin
        r = in_pkt_meta_data;
        r.needs_dsc = 1'b1;
        r.descriptor_only = 1'b0;
        m_merged++;
        take_pkt = 1'b1;
        take_upd = 1'b1;
      end else if (in_pkt_meta_valid && has_upd) begin
        if (turn_dsc) take_upd = 1'b1;
        else          take_pkt = 1'b1;
        turn_dsc = !turn_dsc;
      end else begin
        take_pkt = in_pkt_meta_valid;
        take_upd = has_upd;
      end
      if (take_pkt && !fuse) begin
        r = in_pkt_meta_data;
        r.needs_dsc = 1'b0;
      end else if (take_upd && !fuse) begin
        r = '0;
        r.descriptor_only = 1'b1;
        r.pkt_queue_id = upd;
        m_dsc++;
      end
      if (take_pkt || take_upd) sb.push_back(r);
    end
    chk("pkt_ready", 128'(in_pkt_meta_ready), 128'(take_pkt));
    chk("hu_ready", 128'(in_head_upd_ready), 128'(!full));
    acc_p = take_pkt;
    acc_h = in_head_upd_valid && !full;
    popq  = upd;
    drop  = 1'b0;
`ifdef PKT_DSC_HEAD_COALESCE_EN
    drop = acc_h && pend[in_head_upd_queue_id] &&
           !(take_upd && popq == 32'(in_head_upd_queue_id));
`endif
    if (take_upd) begin
      void'(hq.pop_front());
      pend[popq] = 1'b0;
    end
    if (acc_h) begin
      if (drop) m_coal++;
      else begin
        hq.push_back(32'(in_head_upd_queue_id));
        pend[in_head_upd_queue_id] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 128'(out_meta_valid), 128'(sb.size() > 0));
      if (out_meta_valid && sb.size() > 0) begin
        chk("out_data", 128'(out_meta_data), 128'(sb[0]));
        if (out_meta_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    bit ap, ah;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      in_pkt_meta_valid    = 1'b1;
      in_pkt_meta_data     = mk_pkt($urandom_range(15));
      in_head_upd_valid    = 1'b1;
      in_head_upd_queue_id = QW'($urandom_range(15));
      out_meta_ready       = 1'b1;
      @(negedge clk);
      #1;
      model_step(ap, ah);
    end
    in_pkt_meta_valid = 1'b0;
    in_head_upd_valid = 1'b0;
    plist.delete();
    hlist.delete();
    rst = 1'b1;
  endtask

  // rmode: 0 = ready after stall, 1 = random ready after stall.
  task automatic run(input int stall, input int rmode, input int maxc,
                     input bit gate, input bit drain);
    bit ph = 1'b0;
    bit hh = 1'b0;
    bit ap, ah;
    for (int c = 0; c < maxc; c++) begin
      if (plist.size() == 0 && hlist.size() == 0 &&
          sb.size() == 0 && hq.size() == 0) break;
      @(posedge clk);
      #1;
      in_pkt_meta_valid = (plist.size() > 0) &&
                          (ph || !gate || $urandom_range(3) != 0);
      in_pkt_meta_data  = (plist.size() > 0) ? plist[0]
                                             : mk_pkt($urandom);
      in_head_upd_valid = (hlist.size() > 0) &&
                          (hh || !gate || $urandom_range(3) != 0);
      in_head_upd_queue_id = (hlist.size() > 0) ? QW'(hlist[0])
                                                : QW'($urandom);
      if (c < stall)      out_meta_ready = 1'b0;
      else if (rmode != 0) out_meta_ready = ($urandom_range(9) < 7);
      else                out_meta_ready = 1'b1;
      @(negedge clk);
      #1;
      model_step(ap, ah);
      ph = in_pkt_meta_valid && !ap;
      hh = in_head_upd_valid && !ah;
      if (ap) void'(plist.pop_front());
      if (ah) void'(hlist.pop_front());
    end
    if (drain)
      chk("phase_drained",
          128'(plist.size() + hlist.size() + sb.size() + hq.size()),
          128'(0));
    in_pkt_meta_valid = 1'b0;
    in_head_upd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                  = 1'b0;
    in_pkt_meta_valid    = 1'b0;
    in_pkt_meta_data     = '0;
    in_head_upd_valid    = 1'b0;
    in_head_upd_queue_id = '0;
    out_meta_ready       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();

    // Packets only.
    plist.push_back(mk_pkt(3));
    plist.push_back(mk_pkt(5));
    plist.push_back(mk_pkt(7));
    run(0, 0, 50, 1'b0, 1'b1);

    // Fuse: update 5 lands in the FIFO while packet 5 waits.
    plist.push_back(mk_pkt(100));
    plist.push_back(mk_pkt(5));
    hlist.push_back(5);
    run(3, 0, 50, 1'b0, 1'b1);

    // Round robin between a packet stream and two updates.
    for (int i = 0; i < 6; i++) plist.push_back(mk_pkt(1));
    hlist.push_back(2);
    hlist.push_back(4);
    run(0, 0, 50, 1'b0, 1'b1);

    // Backpressure: twenty distinct updates against a stalled output.
    for (int i = 0; i < 20; i++) hlist.push_back(100 + i);
    run(10, 0, 200, 1'b0, 1'b1);

    // Repeated updates for one queue behind an occupied slot.
    plist.push_back(mk_pkt(200));
    for (int i = 0; i < 5; i++) hlist.push_back(9);
    run(8, 0, 100, 1'b0, 1'b1);

    // Randomized mixed traffic with gaps and random backpressure.
    for (int i = 0; i < 600; i++) plist.push_back(mk_pkt($urandom_range(15)));
    for (int i = 0; i < 500; i++) hlist.push_back($urandom_range(15));
    run(0, 1, 6000, 1'b1, 1'b1);

    // Reset while records are in flight, then more traffic.
    for (int i = 0; i < 6; i++) plist.push_back(mk_pkt($urandom_range(7)));
    for (int i = 0; i < 6; i++) hlist.push_back($urandom_range(7));
    run(3, 0, 4, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 200; i++) plist.push_back(mk_pkt($urandom_range(7)));
    for (int i = 0; i < 200; i++) hlist.push_back($urandom_range(7));
    run(5, 1, 3000, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
